// File: rtl/traffic_pkg.sv
// ============================================================================
// Module : traffic_pkg
// Brief  : Phase codes, timer FSM encoding and phase legality helper shared by
//          the traffic phase timer blocks.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package traffic_pkg;

  localparam logic [2:0] PH_RED    = 3'b001;
  localparam logic [2:0] PH_YELLOW = 3'b010;
  localparam logic [2:0] PH_GREEN  = 3'b100;

  typedef enum logic [1:0] {
    ST_COUNT   = 2'd0,
    ST_ADVANCE = 2'd1,
    ST_LOAD    = 2'd2
  } timer_state_e;

  function automatic logic is_legal_phase(input logic [2:0] ph);
    return (ph == PH_RED) || (ph == PH_YELLOW) || (ph == PH_GREEN);
  endfunction

endpackage

`default_nettype wire

// File: rtl/traffic_phase_timer_if.sv
// ============================================================================
// Module : traffic_phase_timer_if
// Brief  : Control/status bundle between the phase timer and its environment.
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface traffic_phase_timer_if #(
  parameter int CNT_W = 8
);
  logic             tick;
  logic             run;
  logic             ped_req;
  logic [2:0]       nst_in;
  logic [2:0]       pst;
  logic             en;
  logic [CNT_W-1:0] dwell_cnt;
  logic             ped_pend;
  logic             fault;

  modport master (
    output tick, run, ped_req, nst_in,
    input  pst, en, dwell_cnt, ped_pend, fault
  );

  modport slave (
    input  tick, run, ped_req, nst_in,
    output pst, en, dwell_cnt, ped_pend, fault
  );
endinterface

`default_nettype wire

// File: rtl/traffic_dwell_counter.sv
// ============================================================================
// Module : traffic_dwell_counter
// Brief  : Loadable down-counter with decrement enable and zero flag.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module traffic_dwell_counter #(
  parameter int               CNT_W   = 8,
  parameter logic [CNT_W-1:0] RST_VAL = '0
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  input  wire logic             load_i,
  input  wire logic [CNT_W-1:0] load_val_i,
  input  wire logic             dec_i,
  output logic      [CNT_W-1:0] cnt_o,
  output logic                  zero_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= RST_VAL;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign cnt_o  = cnt_q;
  assign zero_o = (cnt_q == '0);

endmodule

`default_nettype wire

// File: rtl/traffic_phase_timer.sv
// ============================================================================
// Module : traffic_phase_timer
// Brief  : Holds the present traffic phase, times its dwell in ticks and hands
//          off to the next-state logic via a 1-clk advance strobe.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module traffic_phase_timer
  import traffic_pkg::*;
#(
  parameter int RED_TICKS    = 20,
  parameter int GREEN_TICKS  = 16,
  parameter int YELLOW_TICKS = 4,
  parameter int PED_CAP      = 3,
  parameter int CNT_W        = 8
) (
  input wire logic               clk,
  input wire logic               rst_n,
  traffic_phase_timer_if.slave   tpt_if
);

  localparam logic [CNT_W-1:0] c_red_ld    = CNT_W'(RED_TICKS - 1);
  localparam logic [CNT_W-1:0] c_green_ld  = CNT_W'(GREEN_TICKS - 1);
  localparam logic [CNT_W-1:0] c_yellow_ld = CNT_W'(YELLOW_TICKS - 1);
  localparam logic [CNT_W-1:0] c_ped_cap   = CNT_W'(PED_CAP);

  timer_state_e     state_q;
  logic [2:0]       pst_q;
  logic             en_q;
  logic             ped_pend_q;
  logic             ped_pend_d;
  logic             fault_q;

  logic [CNT_W-1:0] w_cnt;
  logic             w_zero;
  logic             w_step;
  logic             w_cap;
  logic             w_dec;
  logic             w_load;
  logic             w_nst_ok;
  logic [2:0]       w_new_ph;
  logic [CNT_W-1:0] w_load_val;

  assign w_step   = (state_q == ST_COUNT) && tpt_if.run && tpt_if.tick;
  // Pedestrian shortening replaces the decrement rather than adding to it.
  assign w_cap    = w_step && !w_zero && (pst_q == PH_GREEN) && ped_pend_q
                    && (w_cnt > c_ped_cap);
  assign w_dec    = w_step && !w_zero && !w_cap;
  assign w_load   = (state_q == ST_LOAD) || w_cap;
  assign w_nst_ok = is_legal_phase(tpt_if.nst_in);
  assign w_new_ph = w_nst_ok ? tpt_if.nst_in : PH_RED;

  always_comb begin
    w_load_val = c_red_ld;
    if (w_cap) begin
      w_load_val = c_ped_cap;
    end else begin
      case (w_new_ph)
        PH_GREEN:  w_load_val = c_green_ld;
        PH_YELLOW: w_load_val = c_yellow_ld;
        default:   w_load_val = c_red_ld;
      endcase
    end
  end

  // A new request on the clearing edge keeps the latch set.
  assign ped_pend_d = tpt_if.ped_req
                    | (ped_pend_q & !((state_q == ST_LOAD) && (w_new_ph == PH_RED)));

  traffic_dwell_counter #(
    .CNT_W   (CNT_W),
    .RST_VAL (c_red_ld)
  ) u_dwell (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_i     (w_load),
    .load_val_i (w_load_val),
    .dec_i      (w_dec),
    .cnt_o      (w_cnt),
    .zero_o     (w_zero)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_COUNT;
      pst_q      <= PH_RED;
      en_q       <= 1'b0;
      ped_pend_q <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      ped_pend_q <= ped_pend_d;
      case (state_q)
        ST_COUNT: begin
          if (w_step && w_zero) begin
            state_q <= ST_ADVANCE;
            en_q    <= 1'b1;
          end
        end
        ST_ADVANCE: begin
          state_q <= ST_LOAD;
          en_q    <= 1'b0;
        end
        ST_LOAD: begin
          pst_q   <= w_new_ph;
          state_q <= ST_COUNT;
          if (!w_nst_ok) begin
            fault_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_COUNT;
          en_q    <= 1'b0;
        end
      endcase
    end
  end

  assign tpt_if.pst       = pst_q;
  assign tpt_if.en        = en_q;
  assign tpt_if.dwell_cnt = w_cnt;
  assign tpt_if.ped_pend  = ped_pend_q;
  assign tpt_if.fault     = fault_q;

endmodule

`default_nettype wire

// File: tb/tb_traffic_phase_timer.sv
// ============================================================================
// Module : tb_traffic_phase_timer
// Brief  : Randomised self-checking bench for traffic_phase_timer against a
//          behavioural phase/dwell model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_traffic_phase_timer;

  localparam int RED_T = 3;
  localparam int GRN_T = 4;
  localparam int YEL_T = 2;
  localparam int CAP   = 1;
  localparam int CW    = 8;
  localparam logic [2:0] RED = 3'b001;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  traffic_phase_timer_if #(.CNT_W(CW)) bus ();

  traffic_phase_timer #(
    .RED_TICKS(RED_T), .GREEN_TICKS(GRN_T), .YELLOW_TICKS(YEL_T),
    .PED_CAP(CAP), .CNT_W(CW)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .tpt_if (bus)
  );

  always #5 clk = ~clk;

  // Model: phase, remaining ticks minus one, stage 0=counting 1=strobe 2=capture
  logic [2:0] m_ph;
  int         m_rem;
  int         m_stage;
  logic       m_pend;
  logic       m_flt;

  wire [14:0] dut_vec = {bus.pst, bus.en, bus.dwell_cnt, bus.ped_pend, bus.fault};

  function automatic logic [14:0] exp_vec();
    return {m_ph, (m_stage == 1), 8'(m_rem), m_pend, m_flt};
  endfunction

  function automatic int ticks_of(input logic [2:0] ph);
    if (ph == GRN) return GRN_T;
    if (ph == YEL) return YEL_T;
    return RED_T;
  endfunction

  function automatic logic [2:0] succ(input logic [2:0] ph);
    if (ph == RED) return GRN;
    if (ph == GRN) return YEL;
    return RED;
  endfunction

  task automatic model_reset();
    m_ph = RED; m_rem = RED_T - 1; m_stage = 0; m_pend = 1'b0; m_flt = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic t, input logic p, input logic [2:0] n);
    logic [2:0] nph;
    int nrem, nstage;
    logic nflt;
    nph = m_ph; nrem = m_rem; nstage = m_stage; nflt = m_flt;
    if (m_stage == 0) begin
      if (r && t) begin
        if (m_rem == 0) nstage = 1;
        else if (m_ph == GRN && m_pend && m_rem > CAP) nrem = CAP;
        else nrem = m_rem - 1;
      end
    end else if (m_stage == 1) begin
      nstage = 2;
    end else begin
      if ($countones(n) == 1) begin
        nph = n; nrem = ticks_of(n) - 1;
      end else begin
        nph = RED; nrem = RED_T - 1; nflt = 1'b1;
      end
      nstage = 0;
    end
    m_pend  = p ? 1'b1 : ((m_stage == 2 && nph == RED) ? 1'b0 : m_pend);
    m_ph = nph; m_rem = nrem; m_stage = nstage; m_flt = nflt;
  endtask

  // One clock: drive inputs, advance the model at the edge, settle 1 time unit.
  task automatic cycle(input logic r, input logic t, input logic p, input logic bad);
    logic [2:0] n;
    bus.run = r; bus.tick = t; bus.ped_req = p;
    n = 3'($urandom);
    if (m_stage == 2) n = bad ? 3'b011 : succ(m_ph);
    bus.nst_in = n;
    @(posedge clk);
    model_step(r, t, p, n);
    #1;
  endtask

  task automatic test_reset();
    bus.run = 1'b0; bus.tick = 1'b0; bus.ped_req = 1'b0; bus.nst_in = 3'b000;
    rst_n = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL reset: got %h expected %h", dut_vec, exp_vec());
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sequence();
    int red_len;
    red_len = 0;
    for (int i = 0; i < 45; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      if (i < 5 && bus.pst === RED) red_len++;
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL sequence cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
    checks++;
    if (red_len != 4) begin
      errors++;
      $display("FAIL red_after_reset: got %0d clks expected 4", red_len);
    end
  endtask

  task automatic test_freeze();
    for (int i = 0; i < 40 && !(m_stage == 0 && m_ph == GRN && m_rem == 1); i++)
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!(m_stage == 0 && m_ph == GRN && m_rem == 1)) begin
      errors++;
      $display("FAIL freeze_setup: green dwell 1 got not reached expected reached");
    end
    for (int i = 0; i < 10; i++) begin
      cycle(1'b0, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.pst !== GRN || bus.dwell_cnt !== 8'd1 || bus.en !== 1'b0) begin
        errors++;
        $display("FAIL freeze cyc %0d: got %h expected pst=100 cnt=1 en=0", i, dut_vec);
      end
    end
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL unfreeze cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_ped();
    for (int i = 0; i < 40 && !(m_stage == 0 && m_ph == GRN && m_rem == 3); i++)
      cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (!(m_stage == 0 && m_ph == GRN && m_rem == 3)) begin
      errors++;
      $display("FAIL ped_setup: green start got not reached expected reached");
    end
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, (i == 0), 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL ped cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_slow_tick();
    for (int i = 0; i < 90; i++) begin
      cycle(1'b1, (i % 3 == 0), 1'b0, 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL slow_tick cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_fault();
    for (int i = 0; i < 40 && m_stage != 2; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 1'b0, 1'b1);
    checks++;
    if (bus.pst !== RED || bus.dwell_cnt !== 8'd2 || bus.fault !== 1'b1) begin
      errors++;
      $display("FAIL fault_capture: got %h expected pst=001 cnt=2 fault=1", dut_vec);
    end
    for (int i = 0; i < 25; i++) begin
      cycle(1'b1, 1'b1, 1'($urandom_range(0, 3) == 0), 1'b0);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL fault_sticky cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_adv();
    for (int i = 0; i < 40 && m_stage != 1; i++) cycle(1'b1, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.en !== 1'b1) begin
      errors++;
      $display("FAIL adv_strobe: got en=%b expected 1", bus.en);
    end
    rst_n = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec !== exp_vec()) begin
      errors++;
      $display("FAIL async_reset: got %h expected %h", dut_vec, exp_vec());
    end
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic r, t, p, b;
    for (int i = 0; i < 2000; i++) begin
      r = ($urandom_range(0, 7) != 0);
      t = $urandom_range(0, 1) != 0;
      p = ($urandom_range(0, 9) == 0);
      b = ($urandom_range(0, 15) == 0);
      cycle(r, t, p, b);
      checks++;
      if (dut_vec !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d: got %h expected %h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_sequence();
    test_freeze();
    test_ped();
    test_slow_tick();
    test_fault();
    test_reset_adv();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
